// File: rtl/uart_bus_master.sv
// uart_bus_master: debug bus initiator driven by a UART byte stream.
// Command format: 'R' A3 A2 A1 A0          -> reply D3 D2 D1 D0
//                 'W' A3 A2 A1 A0 D3..D0   -> reply 'K'
// Optional build macro DEBUG_TIMEOUT_EN bounds the wait for bus_response
// and replies ERR_BYTE when the responder never answers.
// Handshakes: rx_valid is a one-cycle strobe (no backpressure); a reply
// byte moves when tx_valid && tx_ready on a rising edge; a bus request
// stays high, with address/data stable, until bus_response is sampled high.
module uart_bus_master #(
  parameter logic [7:0] CMD_READ       = 8'h52,
  parameter logic [7:0] CMD_WRITE      = 8'h57,
  parameter logic [7:0] ACK_BYTE       = 8'h4B,
  parameter logic [7:0] ERR_BYTE       = 8'h45,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        bus_read_request,
  output logic        bus_write_request,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_write_data,
  input  logic [31:0] bus_read_data,
  input  logic        bus_response,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_DATA  = 3'd2,
    S_BUS   = 3'd3,
    S_REPLY = 3'd4
  } state_t;

  state_t      r_state;
  logic        r_is_write;   // latched op: 1 = write, 0 = read
  logic        r_single;     // reply is one byte (write ack or error)
  logic [1:0]  r_cnt;        // byte index in ADDR / DATA / REPLY
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;      // captured read data, shifted out MSB first
  logic [7:0]  r_tx_data;
  logic        r_tx_valid;
  logic        r_rd_req;
  logic        r_wr_req;
  logic        w_timeout;

`ifdef DEBUG_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tcnt;

  // Count BUS cycles without a response; held at zero outside BUS
  always_ff @(posedge clk) begin
    if (rst || r_state != S_BUS) r_tcnt <= '0;
    else if (!bus_response)      r_tcnt <= r_tcnt + 1'b1;
  end

  // Fires on the cycle in which the count would reach TIMEOUT_CYCLES
  assign w_timeout = (r_state == S_BUS) && !bus_response &&
                     (r_tcnt == TW'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{ERR_BYTE, TIMEOUT_CYCLES};
  assign w_timeout    = 1'b0;
`endif

  // Command parser, bus sequencer and reply serializer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_is_write <= 1'b0;
      r_single   <= 1'b0;
      r_cnt      <= 2'd0;
      r_addr     <= 32'h0;
      r_wdata    <= 32'h0;
      r_rdata    <= 32'h0;
      r_tx_data  <= 8'h0;
      r_tx_valid <= 1'b0;
      r_rd_req   <= 1'b0;
      r_wr_req   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (rx_valid && (rx_data == CMD_READ || rx_data == CMD_WRITE)) begin
            r_is_write <= (rx_data == CMD_WRITE);
            r_cnt      <= 2'd0;
            r_state    <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (rx_valid) begin
            r_addr <= {r_addr[23:0], rx_data};
            r_cnt  <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              if (r_is_write) begin
                r_state <= S_DATA;
              end else begin
                r_state  <= S_BUS;
                r_rd_req <= 1'b1;
              end
            end
          end
        end
        S_DATA: begin
          if (rx_valid) begin
            r_wdata <= {r_wdata[23:0], rx_data};
            r_cnt   <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              r_state  <= S_BUS;
              r_wr_req <= 1'b1;
            end
          end
        end
        S_BUS: begin
          // A response in the timeout cycle wins: normal completion
          if (bus_response) begin
            r_rd_req   <= 1'b0;
            r_wr_req   <= 1'b0;
            r_rdata    <= bus_read_data;
            r_single   <= r_is_write;
            r_tx_valid <= 1'b1;
            r_tx_data  <= r_is_write ? ACK_BYTE : bus_read_data[31:24];
            r_cnt      <= 2'd0;
            r_state    <= S_REPLY;
          end else if (w_timeout) begin
            r_rd_req   <= 1'b0;
            r_wr_req   <= 1'b0;
            r_single   <= 1'b1;
            r_tx_valid <= 1'b1;
            r_tx_data  <= ERR_BYTE;
            r_cnt      <= 2'd0;
            r_state    <= S_REPLY;
          end
        end
        S_REPLY: begin
          if (tx_ready) begin
            if (r_single || r_cnt == 2'd3) begin
              r_tx_valid <= 1'b0;
              r_tx_data  <= 8'h0;
              r_state    <= S_IDLE;
            end else begin
              r_cnt     <= r_cnt + 2'd1;
              r_tx_data <= r_rdata[23:16];
              r_rdata   <= {r_rdata[23:0], 8'h00};
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx_data           = r_tx_data;
  assign tx_valid          = r_tx_valid;
  assign bus_read_request  = r_rd_req;
  assign bus_write_request = r_wr_req;
  assign bus_addr          = r_addr;
  assign bus_write_data    = r_wdata;
  assign busy              = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench for uart_bus_master: read, write, garbage/dropped bytes,
// reply backpressure, mid-command reset and (with DEBUG_TIMEOUT_EN) timeout.
module tb_uart_bus_master;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        bus_read_request;
  logic        bus_write_request;
  logic [31:0] bus_addr;
  logic [31:0] bus_write_data;
  logic [31:0] bus_read_data;
  logic        bus_response;
  logic        busy;

  int checks = 0;
  int errors = 0;

  uart_bus_master #(.TIMEOUT_CYCLES(16)) dut (
    .clk               (clk),
    .rst               (rst),
    .rx_data           (rx_data),
    .rx_valid          (rx_valid),
    .tx_data           (tx_data),
    .tx_valid          (tx_valid),
    .tx_ready          (tx_ready),
    .bus_read_request  (bus_read_request),
    .bus_write_request (bus_write_request),
    .bus_addr          (bus_addr),
    .bus_write_data    (bus_write_data),
    .bus_read_data     (bus_read_data),
    .bus_response      (bus_response),
    .busy              (busy)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; strobes one byte across the next posedge
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  // Waits (bounded) for a reply byte, stalls tx_ready, then accepts it
  task automatic get_byte(input logic [7:0] exp, input int stall, input string tag);
    int n = 0;
    while (!tx_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({31'h0, tx_valid}, 32'h1, {tag, "_valid"});
    for (int i = 0; i < stall; i++) begin
      chk({24'h0, tx_data}, {24'h0, exp}, {tag, "_hold"});
      chk({31'h0, tx_valid}, 32'h1, {tag, "_hold_valid"});
      chk({31'h0, busy}, 32'h1, {tag, "_hold_busy"});
      @(negedge clk);
    end
    chk({24'h0, tx_data}, {24'h0, exp}, {tag, "_data"});
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
  endtask

  initial begin
    // Reset
    rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b0;
    bus_read_data = 32'h0; bus_response = 1'b0;
    repeat (3) @(negedge clk);
    chk({31'h0, busy}, 32'h0, "rst_busy");
    chk({31'h0, tx_valid}, 32'h0, "rst_tx_valid");
    chk({30'h0, bus_read_request, bus_write_request}, 32'h0, "rst_req");
    chk(bus_addr, 32'h0, "rst_addr");
    chk(bus_write_data, 32'h0, "rst_wdata");
    rst = 1'b0;
    @(negedge clk);

    // Stray response in IDLE is ignored
    bus_response = 1'b1; bus_read_data = 32'h11111111;
    @(negedge clk);
    bus_response = 1'b0;
    chk({31'h0, busy}, 32'h0, "idle_resp_busy");
    chk({31'h0, tx_valid}, 32'h0, "idle_resp_tx");

    // Read 0x00001000, response in third BUS cycle, reply streamed
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h10); send_byte(8'h00);
    for (int c = 0; c < 3; c++) begin
      chk({31'h0, bus_read_request}, 32'h1, "rd_req");
      chk({31'h0, bus_write_request}, 32'h0, "rd_no_wr");
      chk(bus_addr, 32'h00001000, "rd_addr");
      chk({31'h0, busy}, 32'h1, "rd_busy");
      if (c == 2) begin
        bus_response = 1'b1; bus_read_data = 32'hDEADBEEF;
      end
      @(negedge clk);
    end
    bus_response = 1'b0; bus_read_data = 32'h0;
    chk({31'h0, bus_read_request}, 32'h0, "rd_req_drop");
    chk({31'h0, tx_valid}, 32'h1, "rd_tx_valid");
    chk({24'h0, tx_data}, 32'hDE, "rd_b0");
    tx_ready = 1'b1;
    @(negedge clk); chk({24'h0, tx_data}, 32'hAD, "rd_b1");
    @(negedge clk); chk({24'h0, tx_data}, 32'hBE, "rd_b2");
    @(negedge clk); chk({24'h0, tx_data}, 32'hEF, "rd_b3");
    @(negedge clk);
    chk({31'h0, tx_valid}, 32'h0, "rd_done_tx");
    chk({31'h0, busy}, 32'h0, "rd_done_busy");
    tx_ready = 1'b0;

    // Write 0x000000A5 to 0x00001000, response in first BUS cycle
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h10); send_byte(8'h00);
    chk({31'h0, bus_write_request}, 32'h0, "wr_early_req");
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'hA5);
    chk({31'h0, bus_write_request}, 32'h1, "wr_req");
    chk({31'h0, bus_read_request}, 32'h0, "wr_no_rd");
    chk(bus_addr, 32'h00001000, "wr_addr");
    chk(bus_write_data, 32'h000000A5, "wr_data");
    bus_response = 1'b1;
    @(negedge clk);
    bus_response = 1'b0;
    chk({31'h0, bus_write_request}, 32'h0, "wr_req_drop");
    get_byte(8'h4B, 0, "wr_ack");
    chk({31'h0, tx_valid}, 32'h0, "wr_done_tx");
    chk({31'h0, busy}, 32'h0, "wr_done_busy");

    // Garbage before the command, extra bytes during BUS, stalled reply
    send_byte(8'h00); chk({31'h0, busy}, 32'h0, "garb_00");
    send_byte(8'hFF); chk({31'h0, busy}, 32'h0, "garb_ff");
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h20); send_byte(8'h04);
    chk({31'h0, bus_read_request}, 32'h1, "garb_req");
    send_byte(8'h57); send_byte(8'h11);
    chk({31'h0, bus_read_request}, 32'h1, "garb_req_held");
    chk({31'h0, bus_write_request}, 32'h0, "garb_no_wr");
    chk(bus_addr, 32'h00002004, "garb_addr");
    bus_response = 1'b1; bus_read_data = 32'h12345678;
    @(negedge clk);
    bus_response = 1'b0; bus_read_data = 32'h0;
    get_byte(8'h12, 5, "bp_b0");
    get_byte(8'h34, 5, "bp_b1");
    get_byte(8'h56, 5, "bp_b2");
    get_byte(8'h78, 5, "bp_b3");
    chk({31'h0, tx_valid}, 32'h0, "bp_done_tx");
    chk({31'h0, busy}, 32'h0, "bp_done_busy");

    // Reset after the second address byte, then a full write
    send_byte(8'h57); send_byte(8'hAA); send_byte(8'hBB);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk({31'h0, busy}, 32'h0, "mrst_busy");
    chk(bus_addr, 32'h0, "mrst_addr");
    repeat (3) @(negedge clk);
    chk({30'h0, bus_read_request, bus_write_request}, 32'h0, "mrst_no_req");
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h00); send_byte(8'h40);
    send_byte(8'hCA); send_byte(8'hFE); send_byte(8'hBA); send_byte(8'hBE);
    chk({31'h0, bus_write_request}, 32'h1, "mrst_wr_req");
    chk(bus_addr, 32'h00000040, "mrst_wr_addr");
    chk(bus_write_data, 32'hCAFEBABE, "mrst_wr_data");
    @(negedge clk);
    bus_response = 1'b1;
    @(negedge clk);
    bus_response = 1'b0;
    get_byte(8'h4B, 1, "mrst_ack");
    chk({31'h0, busy}, 32'h0, "mrst_done_busy");

`ifdef DEBUG_TIMEOUT_EN
    // No responder: request must drop after exactly 16 BUS cycles
    begin
      int n;
      send_byte(8'h52); send_byte(8'h00); send_byte(8'h00);
      send_byte(8'h00); send_byte(8'h08);
      n = 0;
      while (bus_read_request && n < 40) begin
        n++;
        @(negedge clk);
      end
      chk(n, 32'd16, "to_cycles");
      chk({31'h0, busy}, 32'h1, "to_busy");
      get_byte(8'h45, 0, "to_err");
      chk({31'h0, busy}, 32'h0, "to_done_busy");
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_bus_master.md
Name: uart_bus_master

Overview:
- Debug bus initiator: turns a byte command stream from a UART receiver into single read/write transactions on the SoC memory/peripheral request–response bus, and returns reply bytes to a UART transmitter.
- Sits beside the processor as a second bus master, in front of an arbiter or mux, so the host can peek and poke memory and LED/GPIO registers without firmware.
- It is the initiator end of the same request/response protocol the memory and peripherals answer as responders.

Parameters:
- CMD_READ, 8'h52, command byte that starts a read ('R').
- CMD_WRITE, 8'h57, command byte that starts a write ('W').
- ACK_BYTE, 8'h4B, reply byte sent after a completed write ('K').
- ERR_BYTE, 8'h45, reply byte sent on bus timeout ('E'); used only with DEBUG_TIMEOUT_EN.
- TIMEOUT_CYCLES, 1024, maximum cycles to wait for bus_response; minimum 2; used only with DEBUG_TIMEOUT_EN.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- rx_data  input  8  received byte.
- rx_valid  input  1  single-cycle strobe; rx_data is valid in that cycle.
- tx_data  output  8  reply byte.
- tx_valid  output  1  reply byte available.
- tx_ready  input  1  transmitter accepts a byte when tx_valid && tx_ready.
- bus_read_request  output  1  read request.
- bus_write_request  output  1  write request.
- bus_addr  output  32  transaction address.
- bus_write_data  output  32  write data.
- bus_read_data  input  32  read data; valid while bus_response=1.
- bus_response  input  1  single-cycle completion pulse from the responder.
- busy  output  1  high in every state except IDLE.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst); all state updates on the rising edge of clk.
- On rst: state=IDLE, all outputs 0, byte counter=0, and address, data and timeout registers cleared.
- States and transitions:
  - IDLE: on rx_valid with CMD_READ or CMD_WRITE, latch the op and go to ADDR. Any other byte is ignored and the block stays in IDLE.
  - ADDR: collect 4 bytes, MSB first (first byte → bus_addr[31:24]). After the 4th byte, a read goes to BUS and a write goes to DATA.
  - DATA: collect 4 bytes, MSB first, into bus_write_data. After the 4th byte, go to BUS.
  - BUS: the request asserts in the first cycle of BUS, one cycle after the last byte strobe.
    - Exactly one of bus_read_request or bus_write_request is high.
    - The request, bus_addr and bus_write_data stay stable until bus_response is sampled high.
    - On that edge, bus_read_data is captured, state goes to REPLY, and the request deasserts in the next cycle.
  - REPLY:
    - A read returns 4 bytes of the captured data, MSB first.
    - A write returns ACK_BYTE.
    - Each byte is held on tx_data with tx_valid=1 until tx_ready=1; the next byte is presented in the following cycle.
    - After the last handshake, go to IDLE with tx_valid=0.
- bus_response while no request is high: ignored.
- rx_valid during BUS or REPLY: byte dropped, no state change.
- The address register is not auto-incremented; every command carries a full address.
- tx_ready held high continuously: one byte is transferred per cycle, so a read reply takes 4 cycles.
- Bus latency is unbounded; the block waits in BUS indefinitely unless the optional feature is compiled in.
- rst mid-transaction (any state): returns to IDLE and drops the request and tx_valid at that edge. A partially received command is discarded.
- Response latency: minimum 1 cycle from request assertion (response in the first BUS cycle is legal).

Optional Feature:
- Macro: DEBUG_TIMEOUT_EN.
- Enabled:
  - A cycle counter clears on BUS entry and increments each BUS cycle without bus_response.
  - When it reaches TIMEOUT_CYCLES, the request deasserts on that edge and state goes to REPLY, which returns the single byte ERR_BYTE for both reads and writes.
  - A response in the same cycle as the timeout takes priority: normal completion.
- Disabled: no counter logic; BUS waits indefinitely for bus_response; ERR_BYTE and TIMEOUT_CYCLES are unused.

Test Plan:
- Read: rx bytes 52 00 00 10 00, responder answers after 3 cycles with 0xDEADBEEF → bus_read_request high with bus_addr=0x00001000 for 3 cycles; tx bytes DE AD BE EF in order.
- Write: rx bytes 57 00 00 10 00 00 00 00 A5, response after 1 cycle → bus_write_request with bus_addr=0x00001000 and bus_write_data=0x000000A5; single tx byte 4B.
- Garbage and dropped bytes: rx 00 FF 52 …; extra rx bytes strobed during BUS → the leading bytes and the extra bytes are ignored; the read completes with the correct address.
- Backpressure: tx_ready low for 5 cycles per byte during a read reply → each byte held stable with tx_valid=1; no byte lost or duplicated; busy stays high until the final handshake.
- Reset mid-operation: assert rst after the 2nd address byte, then send a full write → bus_addr comes only from the new command; no stale request appears after reset.
- DEBUG_TIMEOUT_EN with TIMEOUT_CYCLES=16, no responder → request drops after exactly 16 BUS cycles; tx byte 45; returns to IDLE.
